// File: rtl/vram_arbiter.sv
// Frame-RAM arbiter: scan-out reads own the RAM during active video, queued
// game-logic writes drain during blanking. Define VRAM_ARB_STATS_EN to add stall_cnt.
module vram_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hc_out,
  input  logic [9:0]  vc_out,
  input  logic [15:0] rd_addr,
  output logic [7:0]  rd_data,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        frame_start
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] SCAN  = 2'd2;

  logic             active;
  logic [1:0]       cur_state;
  logic [1:0]       prev_state;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [23:0]      fifo_mem [FIFO_DEPTH];
  logic [15:0]      head_addr;
  logic [7:0]       head_data;
  logic             full;
  logic             push;
  logic             pop;

  assign active = ({1'b0, hc_out} < 11'(H_ACTIVE)) && ({1'b0, vc_out} < 11'(V_ACTIVE));

  // The arbitration state is decoded from this cycle's scan position so that a
  // rising active edge stops draining in the very same cycle.
  always_comb begin
    cur_state = IDLE;
    if (rst)
      cur_state = IDLE;
    else if (active)
      cur_state = SCAN;
    else if (count != '0)
      cur_state = DRAIN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prev_state <= IDLE;
    else
      prev_state <= cur_state;
  end

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign wr_ready = !rst && !full;
  assign push     = wr_req && wr_ready;
  assign pop      = (cur_state == DRAIN);

  assign {head_addr, head_data} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    ram_addr  = 16'h0000;
    ram_wdata = 8'h00;
    ram_we    = 1'b0;
    case (cur_state)
      SCAN:  ram_addr = rd_addr;
      DRAIN: begin
        ram_addr  = head_addr;
        ram_wdata = head_data;
        ram_we    = 1'b1;
      end
      default: ;
    endcase
  end

  // RAM data returned for a scan read lands one cycle later; capture it only then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= 8'h00;
    else if (prev_state == SCAN)
      rd_data <= ram_rdata;
    else
      rd_data <= 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_start <= 1'b0;
    else
      frame_start <= (hc_out == 10'd0) && (vc_out == 10'd0);
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= 16'h0000;
    else if (frame_start)
      stall_cnt <= 16'h0000;
    else if (wr_req && !wr_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'h0001;
  end
`endif

  a_no_write_when_active : assert property (@(posedge clk) disable iff (rst) active |-> !ram_we);
  a_no_push_when_full    : assert property (@(posedge clk) disable iff (rst) full |-> !push);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: scan-out reads, write queue drain, back-pressure,
// drain preemption, reset mid-drain, frame_start, and stall_cnt when enabled.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hc_out;
  logic [9:0]  vc_out;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        frame_start;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int base;

  logic [7:0]  mem [logic [15:0]];
  logic [23:0] wlog [$];

  vram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .hc_out      (hc_out),
    .vc_out      (vc_out),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .frame_start (frame_start)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Unwritten RAM locations read back as the low byte of their address.
  function automatic logic [7:0] rmem(input logic [15:0] a);
    if (mem.exists(a))
      return mem[a];
    return a[7:0];
  endfunction

  always @(posedge clk) begin
    ram_rdata <= rmem(ram_addr);
    if (ram_we) begin
      mem[ram_addr] = ram_wdata;
      wlog.push_back({ram_addr, ram_wdata});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, then drive this cycle's inputs and let them settle.
  task automatic applyStimulus(input int h, input int v, input logic [15:0] ra,
                               input logic wq, input logic [15:0] wa, input logic [7:0] wd);
    @(posedge clk);
    #1;
    hc_out  = 10'(h);
    vc_out  = 10'(v);
    rd_addr = ra;
    wr_req  = wq;
    wr_addr = wa;
    wr_data = wd;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic        exp_we   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        exp_rdy  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] exp_addr [6] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0020, 16'h0000};
  logic [7:0]  exp_data [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB5, 8'h00};

  initial begin
    logic [15:0] e;
    rst     = 1'b1;
    hc_out  = 10'd100;
    vc_out  = 10'd100;
    rd_addr = 16'h1234;
    wr_req  = 1'b1;
    wr_addr = 16'h0055;
    wr_data = 8'h55;

    // Reset state with active scan position and a pending request
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_rd_data", rd_data, 8'h00);
    checkOutput("rst_ram_we", ram_we, 1'b0);
    checkOutput("rst_ram_addr", ram_addr, 16'h0000);
    checkOutput("rst_frame_start", frame_start, 1'b0);
    checkOutput("rst_wr_ready", wr_ready, 1'b0);
    wr_req = 1'b0;
    hc_out = 10'd700;
    vc_out = 10'd0;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", wr_ready, 1'b1);
    checkOutput("post_rst_we", ram_we, 1'b0);

    // Scan line 0: rd_data follows rd_addr two cycles later
    for (int h = 0; h < 640; h++) begin
      applyStimulus(h, 0, 16'(h), 1'b0, 16'h0000, 8'h00);
      e = 16'(h - 2);
      checkOutput("scan_rd_data", rd_data, (h >= 2) ? e[7:0] : 8'h00);
      checkOutput("scan_we", ram_we, 1'b0);
      checkOutput("scan_addr", ram_addr, 16'(h));
      if (h <= 2)
        checkOutput("scan_frame_start", frame_start, (h == 1));
    end

    // Four writes during active fill the queue
    for (int i = 0; i < 4; i++) begin
      applyStimulus(10 + i, 1, 16'h0000, 1'b1, 16'h0010 + 16'(i), 8'hA0 + 8'(i));
      checkOutput("fill_ready", wr_ready, 1'b1);
      checkOutput("fill_we", ram_we, 1'b0);
    end
    // Fifth write held while full
    for (int h = 14; h < 21; h++) begin
      applyStimulus(h, 1, 16'h0000, 1'b1, 16'h0020, 8'hB5);
      checkOutput("full_ready", wr_ready, 1'b0);
      checkOutput("full_we", ram_we, 1'b0);
    end
    base = wlog.size();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(640 + i, 1, 16'h0000, (i < 2), 16'h0020, 8'hB5);
      checkOutput("drain_we", ram_we, exp_we[i]);
      checkOutput("drain_addr", ram_addr, exp_addr[i]);
      if (i < 5)
        checkOutput("drain_data", ram_wdata, exp_data[i]);
      checkOutput("drain_ready", wr_ready, exp_rdy[i]);
    end
    checkOutput("drain_count", wlog.size() - base, 5);
    for (int i = 0; i < 5; i++)
      checkOutput("drain_order", wlog[base + i], {exp_addr[i], exp_data[i]});
    checkOutput("ram_0x13", rmem(16'h0013), 8'hA3);
    checkOutput("ram_0x20", rmem(16'h0020), 8'hB5);

    // Three entries, active returns after one drain cycle
    for (int i = 0; i < 3; i++)
      applyStimulus(i, 2, 16'h0000, 1'b1, 16'h0030 + 16'(i), 8'hC0 + 8'(i));
    base = wlog.size();
    applyStimulus(640, 2, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("pre_we", ram_we, 1'b1);
    checkOutput("pre_addr", ram_addr, 16'h0030);
    for (int h = 0; h < 3; h++) begin
      applyStimulus(h, 3, 16'h0000, 1'b0, 16'h0000, 8'h00);
      checkOutput("pre_active_we", ram_we, 1'b0);
    end
    checkOutput("pre_retained", wlog.size() - base, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(640 + i, 3, 16'h0000, 1'b0, 16'h0000, 8'h00);
      checkOutput("pre_drain_we", ram_we, (i < 2));
    end
    checkOutput("pre_count", wlog.size() - base, 3);
    checkOutput("pre_last", wlog[base + 2], {16'h0032, 8'hC2});

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++)
      applyStimulus(i, 4, 16'h0000, 1'b1, 16'h0040 + 16'(i), 8'hD0 + 8'(i));
    base = wlog.size();
    applyStimulus(640, 4, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("mid_we", ram_we, 1'b1);
    applyStimulus(641, 4, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("mid_addr", ram_addr, 16'h0041);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_we", ram_we, 1'b0);
    checkOutput("mid_rst_addr", ram_addr, 16'h0000);
    checkOutput("mid_rst_ready", wr_ready, 1'b0);
    applyStimulus(641, 4, 16'h0000, 1'b0, 16'h0000, 8'h00);
    applyStimulus(642, 4, 16'h0000, 1'b0, 16'h0000, 8'h00);
    rst = 1'b0;
    #1;
    for (int h = 643; h < 647; h++) begin
      applyStimulus(h, 4, 16'h0000, 1'b0, 16'h0000, 8'h00);
      checkOutput("after_rst_we", ram_we, 1'b0);
    end
    checkOutput("after_rst_count", wlog.size() - base, 1);
    checkOutput("after_rst_0x41", rmem(16'h0041), 8'h41);
    applyStimulus(0, 0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("fs_before", frame_start, 1'b0);
    applyStimulus(1, 0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("fs_pulse", frame_start, 1'b1);
    applyStimulus(2, 0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("fs_after", frame_start, 1'b0);

`ifdef VRAM_ARB_STATS_EN
    for (int i = 0; i < 4; i++)
      applyStimulus(i, 5, 16'h0000, 1'b1, 16'h0050 + 16'(i), 8'hE0 + 8'(i));
    checkOutput("stall_start", stall_cnt, 16'd0);
    for (int h = 4; h < 14; h++)
      applyStimulus(h, 5, 16'h0000, 1'b1, 16'h0060, 8'hEE);
    applyStimulus(14, 5, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("stall_ten", stall_cnt, 16'd10);
    applyStimulus(0, 0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    applyStimulus(1, 0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("stall_hold", stall_cnt, 16'd10);
    applyStimulus(2, 0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    checkOutput("stall_clear", stall_cnt, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 4, write-queue entries (power of two, >=2).
REQ-004 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port hc_out, vc_out  input  10 each  horizontal/vertical scan counters from VGA timing.
REQ-007 Port rd_addr  input  16  scan-out pixel address (graphics side).
REQ-008 Port rd_data  output  8  pixel color RRRGGGBB to VGA.
REQ-009 Port wr_req, wr_addr[16], wr_data[8]  input  game-logic write request.
REQ-010 Port wr_ready  output  1  write accepted when wr_req && wr_ready at a clock edge.
REQ-011 Port ram_addr[16], ram_we[1], ram_wdata[8]  output  single-port frame RAM control.
REQ-012 Port ram_rdata  input  8  RAM synchronous read data, valid one cycle after ram_addr.
REQ-013 Port frame_start  output  1  one-cycle pulse per frame.

Function
REQ-014 active SHALL be (hc_out < H_ACTIVE) && (vc_out < V_ACTIVE), decoded combinationally.
REQ-015 FSM states: IDLE (blank, queue empty), DRAIN (blank, queue non-empty), SCAN (active).
REQ-016 Transitions each cycle: active -> SCAN from any state; !active && count>0 -> DRAIN; !active && count==0 -> IDLE.
REQ-017 SCAN: ram_addr = rd_addr, ram_we = 0; reader has absolute priority, no write ever issued while active.
REQ-018 DRAIN: ram_addr/ram_wdata = queue head, ram_we = 1, head popped same cycle; one write per cycle.
REQ-019 IDLE: ram_we = 0, ram_addr = 0.
REQ-020 rd_data SHALL register ram_rdata when previous cycle was SCAN, else load 8'h00; total latency rd_addr -> rd_data = 2 cycles.
REQ-021 Write queue FIFO_DEPTH entries, FIFO order; writes reach RAM in acceptance order.
REQ-022 wr_ready = !full; when full no push occurs (no bypass), wr_req held by requester.
REQ-023 Simultaneous push and pop (not full): both occur, count unchanged.
REQ-024 Draining of a non-empty queue when active rises: pop stops that same cycle, remaining entries retained.
REQ-025 Count width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
REQ-026 frame_start registered: high for exactly the cycle after hc_out==0 && vc_out==0 sampled.

Reset
REQ-027 While rst high: state IDLE, queue empty, rd_data 0, ram_we 0, ram_addr 0, frame_start 0, wr_ready 0.
REQ-028 wr_ready rises the first cycle after rst deasserts.
REQ-029 Reset mid-operation discards all queued writes; no partial write issued.

Configuration
REQ-030 Macro VRAM_ARB_STATS_EN defined: adds output stall_cnt[16], counting cycles with wr_req && !wr_ready, saturating at 16'hFFFF, cleared to 0 on the frame_start cycle and on reset.
REQ-031 Macro undefined: stall_cnt port and counter absent; all other behaviour identical.

Verification
REQ-032 Reset, then hc_out=0..639/vc_out=0 with rd_addr=hc_out, RAM preloaded addr[7:0] -> rd_data equals addr[7:0] two cycles later, ram_we=0 throughout.
REQ-033 Issue 4 writes (addr 0x0010-0x0013, data 0xA0-0xA3) during active -> wr_ready drops after 4th; at hc_out=640 four consecutive ram_we pulses in order, wr_ready returns.
REQ-034 5th write held during full queue -> not accepted until first drain cycle; then accepted, written last.
REQ-035 Queue with 3 entries, active reasserts after 1 drain -> 1 write issued, 2 retained, drained next blanking.
REQ-036 Assert rst mid-DRAIN with 3 entries -> ram_we=0 immediately, no further writes after release; hc_out=0,vc_out=0 -> frame_start single pulse next cycle.
REQ-037 With VRAM_ARB_STATS_EN: hold wr_req 10 cycles while full -> stall_cnt=10; cleared at next frame_start.
